// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO special-register unit.
package hilo_pkg;

   // Data width carried by a pipeline slot; the top-level W must match.
   localparam int unsigned HILO_W = 32;

   typedef enum logic [2:0] {
      HILO_NONE    = 3'd0,
      HILO_WR_BOTH = 3'd1,
      HILO_WR_HI   = 3'd2,
      HILO_WR_LO   = 3'd3,
      HILO_RD_HI   = 3'd4,
      HILO_RD_LO   = 3'd5
   } hilo_op_e;

   typedef struct packed {
      logic              valid;
      logic              wr_hi;
      logic              wr_lo;
      logic [HILO_W-1:0] hi_val;
      logic [HILO_W-1:0] lo_val;
   } hilo_slot_t;

   localparam hilo_slot_t SLOT_EMPTY = '0;

endpackage

// File: rtl/hilo_slot.sv
// One pending-write pipeline slot (MEM or WB) with clear/load/hold control.
module hilo_slot
   import hilo_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       clear,
   input  hilo_slot_t d,
   output hilo_slot_t q
);

   hilo_slot_t slot_q;

   // Reset and clear drop the pending write; clear wins over load.
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_q <= SLOT_EMPTY;
      end else if (clear) begin
         slot_q <= SLOT_EMPTY;
      end else if (load) begin
         slot_q <= d;
      end
   end

   assign q = slot_q;

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register unit: captures EX writes, pipes them through MEM/WB slots,
// commits to architectural HI/LO and forwards pending values to MFHI/MFLO.
module hilo_unit
   import hilo_pkg::*;
#(
   parameter int unsigned W = HILO_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ex_valid,
   input  logic [2:0]   ex_op,
   input  logic [W-1:0] ex_lo,
   input  logic [W-1:0] ex_hi,
   input  logic [W-1:0] ex_rs,
   input  logic         alu_busy,
   input  logic         stall,
   input  logic         flush,
   output logic [W-1:0] rd_data,
   output logic         hilo_stall,
   output logic [W-1:0] hi,
   output logic [W-1:0] lo
);

   hilo_slot_t   m_d, m_q, b_q;
   logic         is_write, accept, advance;
   logic [W-1:0] hi_q, lo_q;
   logic [W-1:0] fwd_hi, fwd_lo;

   assign is_write = (ex_op == HILO_WR_BOTH) | (ex_op == HILO_WR_HI) | (ex_op == HILO_WR_LO);
   assign accept   = ex_valid & is_write & ~alu_busy & ~stall & ~flush;
   // Flush overrides stall, so the WB slot still drains on a flush.
   assign advance  = flush | ~stall;

   // Build the MEM-slot entry from the EX instruction; a bubble when nothing is accepted.
   always_comb begin
      m_d = SLOT_EMPTY;
      if (accept) begin
         m_d.valid = 1'b1;
         case (ex_op)
            HILO_WR_BOTH: begin
               m_d.wr_hi  = 1'b1;
               m_d.wr_lo  = 1'b1;
               m_d.hi_val = ex_hi;
               m_d.lo_val = ex_lo;
            end
            HILO_WR_HI: begin
               m_d.wr_hi  = 1'b1;
               m_d.hi_val = ex_rs;
            end
            HILO_WR_LO: begin
               m_d.wr_lo  = 1'b1;
               m_d.lo_val = ex_rs;
            end
            default: ;
         endcase
      end
   end

   hilo_slot u_slot_m (
      .clk   (clk),
      .rst   (rst),
      .load  (~stall),
      .clear (flush),
      .d     (m_d),
      .q     (m_q)
   );

   hilo_slot u_slot_b (
      .clk   (clk),
      .rst   (rst),
      .load  (~stall),
      .clear (flush),
      .d     (m_q),
      .q     (b_q)
   );

   // Commit the WB slot into the architectural registers, flagged halves only.
   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (advance && b_q.valid) begin
         if (b_q.wr_hi) hi_q <= b_q.hi_val;
         if (b_q.wr_lo) lo_q <= b_q.lo_val;
      end
   end

   // Youngest pending write to each half wins; other-half writes do not shadow.
   always_comb begin
      fwd_hi = hi_q;
      fwd_lo = lo_q;
      if (b_q.valid && b_q.wr_hi) fwd_hi = b_q.hi_val;
      if (m_q.valid && m_q.wr_hi) fwd_hi = m_q.hi_val;
      if (b_q.valid && b_q.wr_lo) fwd_lo = b_q.lo_val;
      if (m_q.valid && m_q.wr_lo) fwd_lo = m_q.lo_val;
   end

   // Read mux and divide-hazard stall request.
   always_comb begin
      rd_data = '0;
      case (ex_op)
         HILO_RD_HI: rd_data = fwd_hi;
         HILO_RD_LO: rd_data = fwd_lo;
         default:    rd_data = '0;
      endcase
      hilo_stall = ex_valid & alu_busy &
                   ((ex_op == HILO_WR_BOTH) | (ex_op == HILO_RD_HI) | (ex_op == HILO_RD_LO));
   end

   assign hi = hi_q;
   assign lo = lo_q;

endmodule
